// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA front end, START/STOP detection, 7-bit address
// match, register-address pointer and a small byte register file with
// auto-incrementing pointer for both writes and reads.
module i2c_slave_responder #(
   parameter logic [6:0]  SLAVE_ADDRESS          = 7'h50,
   parameter int unsigned DATA_LENGTH            = 8,
   parameter int unsigned REGISTER_ADDRESS_WIDTH = 8,
   parameter int unsigned DEPTH                  = 16,
   localparam int unsigned PTR_W                 = $clog2(DEPTH)
) (
   input  logic                   pclk,
   input  logic                   areset,
   input  logic                   scl_i,
   input  logic                   sda_i,
   output logic                   sda_oe,
   output logic                   busy,
   output logic                   wr_pulse,
   output logic [PTR_W-1:0]       wr_addr,
   output logic [DATA_LENGTH-1:0] wr_data
);

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StReg,
      StRegAck,
      StWrite,
      StWriteAck,
      StRead,
      StReadAck,
      StIgnore
   } state_e;

   // Synchronizer and history flops
   logic scl_s1, scl_s2, scl_h;
   logic sda_s1, sda_s2, sda_h;

   // Bus events derived from synchronized and history samples
   logic scl_rise, scl_fall, scl_high;
   logic start_det, stop_det;

   // Protocol state
   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DATA_LENGTH-1:0]  sr_q, sr_d;
   logic                    rw_q, rw_d;
   logic                    ack_q, ack_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic                    sda_oe_q, sda_oe_d;
   logic                    busy_q, busy_d;
   logic                    wr_pulse_q, wr_pulse_d;
   logic [PTR_W-1:0]        wr_addr_q, wr_addr_d;
   logic [DATA_LENGTH-1:0]  wr_data_q, wr_data_d;

   // Register file
   logic [DATA_LENGTH-1:0]  mem_q [DEPTH];
   logic                    mem_we;
   logic [DATA_LENGTH-1:0]  rd_byte;

   // Synchronize the asynchronous pads; reset to the idle (released) bus level
   // so leaving reset never fakes a START or STOP.
   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_h  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_h  <= 1'b1;
      end else begin
         scl_s1 <= scl_i;
         scl_s2 <= scl_s1;
         scl_h  <= scl_s2;
         sda_s1 <= sda_i;
         sda_s2 <= sda_s1;
         sda_h  <= sda_s2;
      end
   end

   assign scl_rise  = scl_s2 & ~scl_h;
   assign scl_fall  = ~scl_s2 & scl_h;
   assign scl_high  = scl_s2 & scl_h;
   assign start_det = scl_high & sda_h & ~sda_s2;
   assign stop_det  = scl_high & ~sda_h & sda_s2;

   assign rd_byte = mem_q[ptr_q];

   // Protocol state registers
   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         sr_q       <= '0;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         ptr_q      <= '0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         ptr_q      <= ptr_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Register file: cleared on reset, written at the ACK of each data byte
   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[ptr_q] <= sr_q;
      end
   end

   // Next-state logic; START/STOP take priority over any bit event
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      ptr_d      = ptr_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mem_we     = 1'b0;

      if (start_det) begin
         state_d  = StAddr;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (stop_det) begin
         state_d  = StIdle;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               sda_oe_d = 1'b0;
            end

            StAddr: begin
               if (scl_rise) begin
                  sr_d  = {sr_q[DATA_LENGTH-2:0], sda_s2};
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'(DATA_LENGTH)) begin
                  cnt_d = '0;
                  if (sr_q[DATA_LENGTH-1 -: 7] == SLAVE_ADDRESS) begin
                     rw_d     = sr_q[0];
                     state_d  = StAddrAck;
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end

            // End of the address ACK: either wait for the register byte or
            // put the first read bit on the bus right away.
            StAddrAck: begin
               if (scl_fall) begin
                  if (rw_q) begin
                     state_d  = StRead;
                     sr_d     = rd_byte;
                     sda_oe_d = ~rd_byte[DATA_LENGTH-1];
                     cnt_d    = 4'd1;
                  end else begin
                     state_d  = StReg;
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                  end
               end
            end

            StReg: begin
               if (scl_rise) begin
                  sr_d  = {sr_q[DATA_LENGTH-2:0], sda_s2};
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'(REGISTER_ADDRESS_WIDTH)) begin
                  // DEPTH is a power of two, so the low bits are the modulo
                  ptr_d    = sr_q[PTR_W-1:0];
                  sda_oe_d = 1'b1;
                  state_d  = StRegAck;
               end
            end

            StRegAck: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = StWrite;
               end
            end

            StWrite: begin
               if (scl_rise) begin
                  sr_d  = {sr_q[DATA_LENGTH-2:0], sda_s2};
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'(DATA_LENGTH)) begin
                  sda_oe_d   = 1'b1;
                  mem_we     = 1'b1;
                  wr_pulse_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = sr_q;
                  ptr_d      = ptr_q + PTR_W'(1);
                  state_d    = StWriteAck;
               end
            end

            StWriteAck: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = StWrite;
               end
            end

            // sr_q[MSB] is already on the bus; each fall presents the next bit
            // by shifting, and the fall after the last bit releases for the ACK.
            StRead: begin
               if (scl_fall) begin
                  if (cnt_q == 4'(DATA_LENGTH)) begin
                     sda_oe_d = 1'b0;
                     ack_d    = 1'b0;
                     state_d  = StReadAck;
                  end else begin
                     sda_oe_d = ~sr_q[DATA_LENGTH-2];
                     sr_d     = {sr_q[DATA_LENGTH-2:0], 1'b0};
                     cnt_d    = cnt_q + 4'd1;
                  end
               end
            end

            // Master ACK advances the pointer; the next byte goes out on the
            // following fall so SDA never moves while SCL is high.
            StReadAck: begin
               if (scl_rise) begin
                  if (!sda_s2) begin
                     ack_d = 1'b1;
                     ptr_d = ptr_q + PTR_W'(1);
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = StIgnore;
                  end
               end else if (scl_fall && ack_q) begin
                  ack_d    = 1'b0;
                  state_d  = StRead;
                  sr_d     = rd_byte;
                  sda_oe_d = ~rd_byte[DATA_LENGTH-1];
                  cnt_d    = 4'd1;
               end
            end

            StIgnore: begin
               sda_oe_d = 1'b0;
            end

            default: begin
               state_d  = StIdle;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign sda_oe   = sda_oe_q;
   assign busy     = busy_q;
   assign wr_pulse = wr_pulse_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, byte-level reference
// model of the register file, and scoreboard monitors for writes and reads.
module tb_i2c_slave_responder;

   localparam int Q = 50;  // quarter SCL period; one SCL bit is 4*Q = 20 pclk

   logic       pclk = 1'b0;
   logic       areset = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe, busy, wr_pulse;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;

   assign sda_line = sda_m & ~sda_oe;

   always #5 pclk = ~pclk;

   i2c_slave_responder dut (
      .pclk     (pclk),
      .areset   (areset),
      .scl_i    (scl_m),
      .sda_i    (sda_line),
      .sda_oe   (sda_oe),
      .busy     (busy),
      .wr_pulse (wr_pulse),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  model_mem [16];
   wr_t         exp_wr_q [$];
   logic [7:0]  exp_rd_q [$];
   logic [7:0]  got_rd_q [$];
   logic [7:0]  dq [$];
   int          oe_cycles = 0;
   int          busy_cycles = 0;
   logic        prev_oe, prev_scl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write scoreboard: every wr_pulse must match the oldest expected write
   always @(negedge pclk) begin
      if (areset && wr_pulse) begin
         check("wr_expected", exp_wr_q.size(), (exp_wr_q.size() > 0) ? exp_wr_q.size() : 1);
         if (exp_wr_q.size() > 0) begin
            check("wr_addr", wr_addr, exp_wr_q[0].a);
            check("wr_data", wr_data, exp_wr_q[0].d);
            exp_wr_q.delete(0);
         end
      end
   end

   // Read scoreboard: bytes collected from the bus against model predictions
   always @(negedge pclk) begin
      if (got_rd_q.size() > 0) begin
         if (exp_rd_q.size() == 0) begin
            check("rd_unexpected", got_rd_q.size(), 0);
         end else begin
            check("rd_byte", got_rd_q[0], exp_rd_q[0]);
            exp_rd_q.delete(0);
         end
         got_rd_q.delete(0);
      end
   end

   // SDA drive must not change while SCL is high (outside reset)
   always @(negedge pclk) begin
      if (areset && scl_m && prev_scl) check("sda_hold_scl_high", sda_oe, prev_oe);
      prev_oe  <= sda_oe;
      prev_scl <= scl_m;
   end

   // Activity counters for the address-mismatch checks
   always @(negedge pclk) begin
      if (sda_oe) oe_cycles <= oe_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   task automatic clock_bit(input logic b, output logic r);
      sda_m = b;
      #Q scl_m = 1'b1;
      #Q r = sda_line;
      #Q scl_m = 1'b0;
      #Q;
   endtask

   task automatic start_cond();
      sda_m = 1'b1;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b0;
      #Q scl_m = 1'b0;
      #Q;
   endtask

   task automatic stop_cond();
      sda_m = 1'b0;
      #Q scl_m = 1'b1;
      #Q sda_m = 1'b1;
      #Q;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
      clock_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, r);
         b[i] = r;
      end
      clock_bit(~master_ack, r);
   endtask

   // Write transaction; bytes to a foreign address must all be NACKed
   task automatic do_write(input logic [6:0] addr, input logic [7:0] rg,
                           input logic [7:0] data [$]);
      logic ack;
      bit   match;
      int   p, oe0, busy0;
      match = (addr == 7'h50);
      oe0   = oe_cycles;
      busy0 = busy_cycles;
      start_cond();
      write_byte({addr, 1'b0}, ack);
      check("addr_ack", ack, match);
      write_byte(rg, ack);
      check("reg_ack", ack, match);
      p = rg % 16;
      foreach (data[i]) begin
         if (match) begin
            exp_wr_q.push_back('{a: 4'(p), d: data[i]});
            model_mem[p] = data[i];
            p = (p + 1) % 16;
         end
         write_byte(data[i], ack);
         check("data_ack", ack, match);
      end
      check("busy_before_stop", busy, match);
      stop_cond();
      check("busy_after_stop", busy, 0);
      if (!match) begin
         check("mismatch_sda_driven", oe_cycles - oe0, 0);
         check("mismatch_busy", busy_cycles - busy0, 0);
      end
   endtask

   // Combined read: set pointer, repeated START, read n bytes, NACK the last
   task automatic do_read(input logic [7:0] rg, input int n);
      logic       ack;
      logic [7:0] b;
      int         p;
      start_cond();
      write_byte(8'hA0, ack);
      check("rd_addr_w_ack", ack, 1);
      write_byte(rg, ack);
      check("rd_reg_ack", ack, 1);
      start_cond();
      write_byte(8'hA1, ack);
      check("rd_addr_r_ack", ack, 1);
      p = rg % 16;
      for (int i = 0; i < n; i++) begin
         exp_rd_q.push_back(model_mem[p]);
         read_byte(i < n - 1, b);
         got_rd_q.push_back(b);
         p = (p + 1) % 16;
      end
      check("oe_after_nack", sda_oe, 0);
      stop_cond();
      check("busy_after_read_stop", busy, 0);
   endtask

   initial begin
      logic       ack, r, exp_bit;
      logic [6:0] a;
      int         op, n;
      logic [7:0] rg;

      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      repeat (3) @(negedge pclk);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_pulse", wr_pulse, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      areset = 1'b1;
      repeat (5) @(negedge pclk);

      // Basic write of two bytes from register 2
      dq.delete();
      dq.push_back(8'hA5);
      dq.push_back(8'h5A);
      do_write(7'h50, 8'h02, dq);

      // Combined read back of those two bytes
      do_read(8'h02, 2);

      // Foreign address: ignored entirely
      dq.delete();
      dq.push_back(8'h11);
      do_write(7'h51, 8'h11, dq);

      // Pointer wrap 15 -> 0, then read index 0
      dq.delete();
      dq.push_back(8'h11);
      dq.push_back(8'h22);
      do_write(7'h50, 8'h0F, dq);
      do_read(8'h00, 1);

      // Reset while the target drives a 0 bit (MSB of mem[15] = 0x11)
      start_cond();
      write_byte(8'hA0, ack);
      write_byte(8'h0F, ack);
      start_cond();
      write_byte(8'hA1, ack);
      check("rd_reset_addr_ack", ack, 1);
      exp_bit = ~model_mem[15][7];
      check("rd_first_bit_drive", sda_oe, exp_bit);
      scl_m = 1'b1;
      #Q;
      @(negedge pclk);
      areset = 1'b0;
      #1;
      check("reset_releases_sda", sda_oe, 0);
      check("reset_busy", busy, 0);
      check("reset_wr_addr", wr_addr, 0);
      check("reset_wr_data", wr_data, 0);
      sda_m = 1'b1;
      repeat (5) @(negedge pclk);
      areset = 1'b1;
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      repeat (5) @(negedge pclk);
      do_read(8'h0F, 2);

      // STOP three bits into a data byte: nothing committed
      start_cond();
      write_byte(8'hA0, ack);
      write_byte(8'h05, ack);
      clock_bit(1'b1, r);
      clock_bit(1'b0, r);
      clock_bit(1'b1, r);
      stop_cond();
      check("stop_mid_byte_busy", busy, 0);
      check("stop_mid_byte_sda", sda_oe, 0);
      dq.delete();
      dq.push_back(8'h3C);
      do_write(7'h50, 8'h07, dq);
      do_read(8'h07, 1);

      // Randomized mix of writes, reads and foreign-address writes
      for (int k = 0; k < 14; k++) begin
         op = int'($urandom_range(0, 2));
         n  = int'($urandom_range(1, 4));
         rg = 8'($urandom_range(0, 255));
         dq.delete();
         for (int j = 0; j < n; j++) dq.push_back(8'($urandom));
         if (op == 0) begin
            do_write(7'h50, rg, dq);
         end else if (op == 1) begin
            do_read(rg, n);
         end else begin
            a = 7'($urandom_range(0, 127));
            if (a == 7'h50) a = 7'h51;
            do_write(a, rg, dq);
         end
      end

      repeat (20) @(negedge pclk);
      check("wr_queue_drained", exp_wr_q.size(), 0);
      check("rd_queue_drained", exp_rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
